// File: rtl/parking_time_log_pkg.sv
// Shared defaults for the parking time log, the gate controller and the fee logic.
// Contents: default timer width and slot count. Slots need no enum because each one
// is only a FREE/BUSY bit.
package parking_time_log_pkg;

    localparam int unsigned DefTimeW = 11;
    localparam int unsigned DefSlots = 4;

endpackage

// File: rtl/parking_time_log_if.sv
// Request/response bundle between the gate/sensor controller and the parking time log.
// The master side is the controller. It drives the timer, the entry requests and the
// exit requests. The slave side is the log. It drives the acks, the errors, elapsed
// and the occupancy status.
interface parking_time_log_if
    import parking_time_log_pkg::*;
#(
    parameter int unsigned TIME_W = DefTimeW,
    parameter int unsigned SLOTS  = DefSlots
);

    localparam int unsigned SLOT_W = $clog2(SLOTS);

    logic [TIME_W-1:0] timer;
    logic              entry_req;
    logic [SLOT_W-1:0] entry_slot;
    logic              exit_req;
    logic [SLOT_W-1:0] exit_slot;

    logic              entry_ack;
    logic              entry_err;
    logic [SLOT_W-1:0] ack_slot;
    logic              exit_valid;
    logic              exit_err;
    logic [TIME_W-1:0] elapsed;
    logic [SLOTS-1:0]  occupied;
    logic [SLOT_W:0]   count;
    logic              full;
    logic              empty;

    modport master (
        output timer, entry_req, entry_slot, exit_req, exit_slot,
        input  entry_ack, entry_err, ack_slot, exit_valid, exit_err, elapsed,
        input  occupied, count, full, empty
    );

    modport slave (
        input  timer, entry_req, entry_slot, exit_req, exit_slot,
        output entry_ack, entry_err, ack_slot, exit_valid, exit_err, elapsed,
        output occupied, count, full, empty
    );

endinterface

// File: rtl/parking_time_log_lowest_free_slot.sv
// Combinational priority encoder that returns the lowest-index set bit of free.
// Ports:
//   free  in   SLOTS   per-slot free flags
//   idx   out  SLOT_W  index of the lowest free slot (0 when none are free)
//   any   out  1       at least one slot is free
module parking_time_log_lowest_free_slot #(
    parameter int unsigned SLOTS  = 4,
    parameter int unsigned SLOT_W = $clog2(SLOTS)
) (
    input  logic [SLOTS-1:0]  free,
    output logic [SLOT_W-1:0] idx,
    output logic              any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan from the top so that the lowest free index is the last one written.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (free[i]) begin
                idx = SLOT_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_time_log.sv
// Multi-slot entry-timestamp store. An accepted entry captures the timer for its slot.
// An accepted exit returns the elapsed time (timer - stamp), computed modulo
// 2^TIME_W, and frees the slot.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; wins over any same-cycle request
//   bus    slave side of parking_time_log_if. It carries:
//            inputs:  timer, entry_req/entry_slot, exit_req/exit_slot
//            outputs: entry_ack/entry_err/ack_slot, exit_valid/exit_err/elapsed,
//                     occupied, count, full, empty
// All outputs are registered. Pulses last exactly one cycle.
module parking_time_log
    import parking_time_log_pkg::*;
#(
    parameter int unsigned TIME_W    = DefTimeW,
    parameter int unsigned SLOTS     = DefSlots,
    parameter bit          AUTO_SLOT = 1'b0
) (
    input logic               clk,
    input logic               reset,
    parking_time_log_if.slave bus
);

    localparam int unsigned SLOT_W = $clog2(SLOTS);
    localparam int unsigned CNT_W  = SLOT_W + 1;

    logic [TIME_W-1:0] stamp_q [SLOTS];
    logic [SLOTS-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              entry_ack_q, entry_err_q, exit_valid_q, exit_err_q;
    logic              full_q, empty_q;
    logic [SLOT_W-1:0] ack_slot_q;
    logic [TIME_W-1:0] elapsed_q;

    logic [SLOTS-1:0]  exit_sel, entry_sel, exit_clear, free_after_exit;
    logic              exit_hit, entry_hit;
    logic [SLOT_W-1:0] auto_idx, target;
    logic              auto_any;
    logic [TIME_W-1:0] exit_stamp;

    // The free map already has the same-cycle exit applied, so an entry can reuse the
    // slot that an exit releases in the same cycle.
    parking_time_log_lowest_free_slot #(
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W)
    ) u_lowest_free (
        .free (free_after_exit),
        .idx  (auto_idx),
        .any  (auto_any)
    );

    always_comb begin
        exit_sel   = '0;
        entry_sel  = '0;
        exit_stamp = '0;
        // Decoding by comparison leaves an out-of-range index with an empty select.
        // Entry then sees the slot as busy, and exit sees it as empty.
        for (int i = 0; i < SLOTS; i++) begin
            if (bus.exit_slot == SLOT_W'(i)) begin
                exit_sel[i] = 1'b1;
            end
        end
        exit_hit = bus.exit_req && |(exit_sel & occ_q);
        for (int i = 0; i < SLOTS; i++) begin
            if (exit_sel[i]) begin
                exit_stamp = stamp_q[i];
            end
        end

        exit_clear      = exit_hit ? exit_sel : '0;
        free_after_exit = ~occ_q | exit_clear;

        target = AUTO_SLOT ? auto_idx : bus.entry_slot;
        for (int i = 0; i < SLOTS; i++) begin
            if (target == SLOT_W'(i)) begin
                entry_sel[i] = 1'b1;
            end
        end
        entry_hit = bus.entry_req &&
                    (AUTO_SLOT ? auto_any : |(entry_sel & free_after_exit));

        occ_d   = (occ_q & ~exit_clear) | (entry_hit ? entry_sel : '0);
        count_d = count_q + CNT_W'(entry_hit) - CNT_W'(exit_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                stamp_q[i] <= '0;
            end
            occ_q        <= '0;
            count_q      <= '0;
            entry_ack_q  <= 1'b0;
            entry_err_q  <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_err_q   <= 1'b0;
            ack_slot_q   <= '0;
            elapsed_q    <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            entry_ack_q  <= entry_hit;
            entry_err_q  <= bus.entry_req && !entry_hit;
            exit_valid_q <= exit_hit;
            exit_err_q   <= bus.exit_req && !exit_hit;
            if (exit_hit) begin
                // Modular subtraction handles one timer wrap between entry and exit.
                elapsed_q <= bus.timer - exit_stamp;
            end
            if (entry_hit) begin
                ack_slot_q <= target;
            end
            for (int i = 0; i < SLOTS; i++) begin
                if (entry_hit && entry_sel[i]) begin
                    stamp_q[i] <= bus.timer;
                end
            end
            occ_q   <= occ_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(SLOTS));
            empty_q <= (count_d == '0);
        end
    end

    assign bus.entry_ack  = entry_ack_q;
    assign bus.entry_err  = entry_err_q;
    assign bus.ack_slot   = ack_slot_q;
    assign bus.exit_valid = exit_valid_q;
    assign bus.exit_err   = exit_err_q;
    assign bus.elapsed    = elapsed_q;
    assign bus.occupied   = occ_q;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;

endmodule
